// File: rtl/data_mem_resp.sv
// Data-memory responder for the single-cycle core's data port.
// Loads are answered combinationally from a word RAM. Stores are posted into a
// one-entry write buffer and written into the array on a later edge. Loads
// forward from that buffer. The block also keeps a sticky error flag that
// records the first bad address, and saturating load/store counters.
module data_mem_resp #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_ce_i,
   input  logic        data_we_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        err_o,
   output logic [31:0] err_addr_o,
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o
);

   localparam int          AW    = $clog2(DEPTH_WORDS);
   // Byte size of the array, held in 33 bits so it cannot wrap for large depths.
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wb_state_t;

   wb_state_t         state;
   wb_state_t         state_next;
   logic              wb_valid;
   logic              drain_en;
   logic [AW-1:0]     wb_idx;
   logic [31:0]       wb_data;
   logic [31:0]       mem [DEPTH_WORDS];

   logic [31:0]       off;
   logic [AW-1:0]     idx;
   logic              addr_ok;
   logic              load_ok;
   logic              store_ok;
   logic              bad_access;

   // Address decode. A wrapped address that is below BASE_ADDR produces a large offset and fails the range test.
   always_comb begin
      off        = data_addr_i - BASE_ADDR;
      idx        = off[AW+1:2];
      addr_ok    = (off[1:0] == 2'b00) && ({1'b0, off} < LIMIT);
      load_ok    = data_ce_i && !data_we_i && addr_ok;
      store_ok   = data_ce_i &&  data_we_i && addr_ok;
      bad_access = data_ce_i && !addr_ok;
   end

   // Write-buffer state register. Reset throws away any pending store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // Next state: a valid store fills the buffer. Any other edge empties it.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (store_ok)  state_next = FULL;
         FULL:    if (!store_ok) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // FSM outputs. A full buffer always drains on the next edge, whether it is refilled or emptied.
   always_comb begin
      wb_valid = (state == FULL);
      drain_en = (state == FULL);
   end

   // Buffer payload, loaded by each valid store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_idx  <= '0;
         wb_data <= '0;
      end else if (store_ok) begin
         wb_idx  <= idx;
         wb_data <= data_i;
      end
   end

   // The array has no reset. The only thing that writes it is the buffer drain.
   always_ff @(posedge clk) begin
      if (drain_en) mem[wb_idx] <= wb_data;
   end

   // Load data. A pending buffer entry with a matching index takes priority over the array contents.
   always_comb begin
      data_o = '0;
      if (load_ok) begin
         if (wb_valid && (wb_idx == idx)) data_o = wb_data;
         else                             data_o = mem[idx];
      end
   end

   // Sticky error flag. Only the first bad address is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o      <= 1'b0;
         err_addr_o <= '0;
      end else if (bad_access) begin
         err_o <= 1'b1;
         if (!err_o) err_addr_o <= data_addr_i;
      end
   end

   // Saturating counters of accepted loads and stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else begin
         if (load_ok  && (rd_cnt_o != 32'hFFFF_FFFF)) rd_cnt_o <= rd_cnt_o + 32'd1;
         if (store_ok && (wr_cnt_o != 32'hFFFF_FFFF)) wr_cnt_o <= wr_cnt_o + 32'd1;
      end
   end

endmodule
